// File: rtl/vx_smem_responder_if.sv
// Request/response bundle between the execute-side requester and the shared-memory responder.
// One batch of NUM_REQS lanes per request handshake, one response beat per read batch.
interface vx_smem_responder_if #(
  parameter int NUM_REQS   = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]                 req_valid;
  logic [NUM_REQS-1:0]                 req_rw;
  logic [NUM_REQS-1:0][3:0]            req_byteen;
  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQS-1:0][31:0]           req_data;
  logic [TAG_WIDTH-1:0]                req_tag;
  logic [NUM_REQS-1:0]                 req_ready;

  logic                                rsp_valid;
  logic [NUM_REQS-1:0]                 rsp_tmask;
  logic [NUM_REQS-1:0][31:0]           rsp_data;
  logic [TAG_WIDTH-1:0]                rsp_tag;
  logic                                rsp_ready;

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_smem_responder.sv
// Shared-memory responder: accepts one lane batch, services it from banked storage
// (one lane per bank per cycle, lowest lane first), then returns the read lanes in one beat.
module vx_smem_responder #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_BANKS  = 4,
  parameter int SIZE       = 1024,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  vx_smem_responder_if.slave bus
);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int WADDR_W = $clog2(SIZE);
  localparam int ROW_W   = WADDR_W - BANK_W;
  localparam int ROWS    = SIZE / NUM_BANKS;
  localparam int LANE_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic [1:0] {IDLE, SERVE, RSP} state_e;

  state_e                           state_q, state_d;
  logic                             ready_q, ready_d;
  logic [NUM_REQS-1:0]              pending_q, pending_d;
  logic [NUM_REQS-1:0]              read_mask_q, read_mask_d;
  logic [NUM_REQS-1:0]              rw_q, rw_d;
  logic [NUM_REQS-1:0][3:0]         byteen_q, byteen_d;
  logic [NUM_REQS-1:0][WADDR_W-1:0] addr_q, addr_d;
  logic [NUM_REQS-1:0][31:0]        data_q, data_d;
  logic [TAG_WIDTH-1:0]             tag_q, tag_d;
  logic [NUM_REQS-1:0][31:0]        buf_q, buf_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [NUM_REQS-1:0]              rsp_tmask_q, rsp_tmask_d;
  logic [TAG_WIDTH-1:0]             rsp_tag_q, rsp_tag_d;

  logic [NUM_BANKS-1:0] sel_valid;
  logic [LANE_W-1:0]    sel_lane [NUM_BANKS];
  logic [NUM_REQS-1:0]  svc_mask;
  logic [31:0]          rd_word  [NUM_BANKS];

  // Address bits above the memory size wrap and are never stored.
  logic unused_addr_bits;
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int l = 0; l < NUM_REQS; l++)
      unused_addr_bits = unused_addr_bits ^ (^bus.req_addr[l][ADDR_WIDTH-1:WADDR_W]);
  end

  // Per-bank arbitration: scanning lanes downwards leaves the lowest pending lane selected.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid = '0;
    svc_mask  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_lane[b] = '0;
      for (int l = NUM_REQS - 1; l >= 0; l--) begin
        if (pending_q[l] && (addr_q[l][BANK_W-1:0] == BANK_W'(b))) begin
          sel_valid[b] = 1'b1;
          sel_lane[b]  = LANE_W'(l);
        end
      end
      if (sel_valid[b]) svc_mask[sel_lane[b]] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [31:0]      mem [ROWS];
    logic [ROW_W-1:0] row;
    logic             we;

    assign row        = addr_q[sel_lane[b]][WADDR_W-1:BANK_W];
    assign we         = (state_q == SERVE) && sel_valid[b] && rw_q[sel_lane[b]];
    assign rd_word[b] = mem[row];

    // NOTE: storage arrays carry no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (byteen_q[sel_lane[b]][i]) mem[row][8*i +: 8] <= data_q[sel_lane[b]][8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    pending_d   = pending_q;
    read_mask_d = read_mask_q;
    rw_d        = rw_q;
    byteen_d    = byteen_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tag_d       = tag_q;
    buf_d       = buf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_tmask_d = rsp_tmask_q;
    rsp_tag_d   = rsp_tag_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && (|bus.req_valid)) begin
          state_d     = SERVE;
          ready_d     = 1'b0;
          pending_d   = bus.req_valid;
          read_mask_d = bus.req_valid & ~bus.req_rw;
          rw_d        = bus.req_rw;
          byteen_d    = bus.req_byteen;
          data_d      = bus.req_data;
          tag_d       = bus.req_tag;
          buf_d       = '0;
          for (int l = 0; l < NUM_REQS; l++) addr_d[l] = bus.req_addr[l][WADDR_W-1:0];
        end
      end
      SERVE: begin
        pending_d = pending_q & ~svc_mask;
        for (int b = 0; b < NUM_BANKS; b++)
          if (sel_valid[b] && !rw_q[sel_lane[b]]) buf_d[sel_lane[b]] = rd_word[b];
        if (pending_d == '0) begin
          if (|read_mask_q) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_tmask_d = read_mask_q;
            rsp_tag_d   = tag_q;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_tmask_d = '0;
          rsp_tag_d   = '0;
          buf_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      pending_q   <= '0;
      read_mask_q <= '0;
      rw_q        <= '0;
      byteen_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      buf_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      pending_q   <= pending_d;
      read_mask_q <= read_mask_d;
      rw_q        <= rw_d;
      byteen_q    <= byteen_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      buf_q       <= buf_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tmask_q <= rsp_tmask_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign bus.req_ready = {NUM_REQS{ready_q}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tmask = rsp_tmask_q;
  assign bus.rsp_data  = buf_q;
  assign bus.rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_vx_smem_responder.sv
// Bench for vx_smem_responder: table of batches with constant expectations, a response
// scoreboard queue, and hand-written backpressure and reset-abort sequences.
module tb_vx_smem_responder;
  localparam int NR = 4;
  localparam int AW = 30;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_smem_responder_if #(.NUM_REQS(NR), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  vx_smem_responder #(
    .NUM_REQS(NR), .NUM_BANKS(4), .SIZE(1024), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    string               name;
    logic [NR-1:0]       valid;
    logic [NR-1:0]       rw;
    logic [15:0]         be;
    logic [4*AW-1:0]     addr;
    logic [127:0]        data;
    logic [TW-1:0]       tag;
    int                  k;
    logic [NR-1:0]       tm;
    logic [127:0]        ed;
  } vec_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [NR-1:0] tmask;
    logic [127:0]  data;
  } rsp_t;

  rsp_t exp_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] valid, input logic [3:0] rw,
                              input logic [15:0] be, input logic [119:0] addr,
                              input logic [127:0] data, input logic [7:0] tag, input int k,
                              input logic [3:0] tm, input logic [127:0] ed);
    vec_t v;
    v.name = nm; v.valid = valid; v.rw = rw; v.be = be; v.addr = addr; v.data = data;
    v.tag = tag; v.k = k; v.tm = tm; v.ed = ed;
    return v;
  endfunction

  task automatic push_exp(input logic [7:0] tag, input logic [3:0] tm, input logic [127:0] ed);
    rsp_t e;
    e.tag = tag; e.tmask = tm; e.data = ed;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input string name);
    rsp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s sb_empty: response tag %0h with nothing expected", name, bus.rsp_tag);
    end else begin
      e = exp_q.pop_front();
      check({name, " tmask"}, bus.rsp_tmask, e.tmask);
      check({name, " data"},  bus.rsp_data,  e.data);
      check({name, " tag"},   bus.rsp_tag,   e.tag);
    end
  endtask

  // Starts and ends at a negedge; returns in the first cycle after the accepting edge.
  task automatic issue(input logic [3:0] valid, input logic [3:0] rw, input logic [15:0] be,
                       input logic [119:0] addr, input logic [127:0] data, input logic [7:0] tag);
    int n;
    n = 0;
    while (bus.req_ready[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.req_ready, 4'hF);
    bus.req_valid  = valid;
    bus.req_rw     = rw;
    bus.req_byteen = be;
    bus.req_addr   = addr;
    bus.req_data   = data;
    bus.req_tag    = tag;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    check("ready_drop", bus.req_ready, 4'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    rsp_t dummy;
    if (v.tm != '0) push_exp(v.tag, v.tm, v.ed);
    issue(v.valid, v.rw, v.be, v.addr, v.data, v.tag);
    n = 1;
    if (v.tm != '0) begin
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check({v.name, " rsp_lat"}, n, 1 + v.k);
      if (bus.rsp_valid === 1'b1) sb_compare(v.name);
      else if (exp_q.size() != 0) dummy = exp_q.pop_back();
      @(negedge clk);
      check({v.name, " post_rsp"}, {bus.req_ready, bus.rsp_valid}, {4'hF, 1'b0});
    end else begin
      while (bus.req_ready[0] !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check({v.name, " wr_lat"}, n, 1 + v.k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;

    vecs[0]  = mk("wr_a", 4'hF, 4'hF, 16'hFFFF, {30'd3, 30'd2, 30'd1, 30'd0},
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h01, 1, 4'h0, '0);
    vecs[1]  = mk("rd_a", 4'hF, 4'h0, 16'h0, {30'd3, 30'd2, 30'd1, 30'd0},
                  '0, 8'h5A, 1, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    vecs[2]  = mk("wr_b", 4'h7, 4'h7, 16'hFFFF, {30'd0, 30'd12, 30'd8, 30'd4},
                  {32'h0, 32'hBC, 32'hB8, 32'hB4}, 8'h02, 3, 4'h0, '0);
    vecs[3]  = mk("rd_conf4", 4'hF, 4'h0, 16'h0, {30'd12, 30'd8, 30'd4, 30'd0},
                  '0, 8'h22, 4, 4'hF, {32'hBC, 32'hB8, 32'hB4, 32'hA0});
    vecs[4]  = mk("wr_same7", 4'hA, 4'hA, 16'hFFFF, {30'd7, 30'd0, 30'd7, 30'd0},
                  {32'h33, 32'h0, 32'h11, 32'h0}, 8'h03, 2, 4'h0, '0);
    vecs[5]  = mk("rd_7", 4'h4, 4'h0, 16'h0, {30'd0, 30'd7, 30'd0, 30'd0},
                  '0, 8'h33, 1, 4'h4, {32'h0, 32'h33, 32'h0, 32'h0});
    vecs[6]  = mk("wr_9_ff", 4'h1, 4'h1, 16'h000F, {90'd0, 30'd9},
                  {96'd0, 32'hFFFF_FFFF}, 8'h04, 1, 4'h0, '0);
    vecs[7]  = mk("wr_9_be", 4'h1, 4'h1, 16'h0005, {90'd0, 30'd9},
                  {96'd0, 32'h1234_5678}, 8'h05, 1, 4'h0, '0);
    vecs[8]  = mk("rd_9", 4'h1, 4'h0, 16'h0, {90'd0, 30'd9},
                  '0, 8'h44, 1, 4'h1, {96'd0, 32'hFF34_FF78});
    vecs[9]  = mk("hazard", 4'hF, 4'h5, 16'hFFFF, {30'd1, 30'd16, 30'd16, 30'd16},
                  {32'h0, 32'hDEAD_0002, 32'h0, 32'hC0DE_0001}, 8'h66, 3, 4'hA,
                  {32'hA1, 32'h0, 32'hC0DE_0001, 32'h0});
    vecs[10] = mk("rd_16", 4'h1, 4'h0, 16'h0, {90'd0, 30'd16},
                  '0, 8'h67, 1, 4'h1, {96'd0, 32'hDEAD_0002});
    vecs[11] = mk("wrap", 4'h3, 4'h0, 16'h0, {30'd0, 30'd0, 30'h2000_0003, 30'h402},
                  '0, 8'h68, 1, 4'h3, {32'h0, 32'h0, 32'hA3, 32'hA2});

    reset          = 1'b0;
    bus.req_valid  = '0;
    bus.req_rw     = '0;
    bus.req_byteen = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {bus.req_ready, bus.rsp_valid, bus.rsp_tmask, bus.rsp_data, bus.rsp_tag}, '0);
    reset = 1'b1;
    #1 check("ready_before_edge", bus.req_ready, 4'h0);
    @(negedge clk);
    check("ready_first_edge", bus.req_ready, 4'hF);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure on a mixed read/write batch: response must hold while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    push_exp(8'h99, 4'b0101, {32'h0, 32'h55, 32'h0, 32'hA0});
    issue(4'hF, 4'b1010, 16'hFFFF, {30'd6, 30'd5, 30'd5, 30'd0},
          {32'h66, 32'h0, 32'h55, 32'h0}, 8'h99);
    n = 1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mixed rsp_lat", n, 3);
    sb_compare("mixed");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mixed hold",
            {bus.rsp_valid, bus.rsp_tmask, bus.rsp_data, bus.rsp_tag, bus.req_ready},
            {1'b1, 4'b0101, {32'h0, 32'h55, 32'h0, 32'hA0}, 8'h99, 4'h0});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("mixed release", {bus.req_ready, bus.rsp_valid}, {4'hF, 1'b0});

    // Reset in the middle of a 4-way conflicted read: the batch and its response are dropped.
    issue(4'hF, 4'h0, 16'h0, {30'd12, 30'd8, 30'd4, 30'd0}, '0, 8'h77);
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort outputs", {bus.rsp_valid, bus.req_ready}, {1'b0, 4'h0});
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort ready_low", bus.req_ready, 4'h0);
    @(negedge clk);
    check("abort ready_back", bus.req_ready, 4'hF);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort no_rsp", seen, 0);

    run_vec(vecs[1]);
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
